// File: rtl/list_cache_pkg.sv
// Shared widths, pointer type and default parameters for the list stream cache.
// Optional TLAST tracking is enabled by defining LIST_STREAM_CACHE_LAST_EN.
package list_cache_pkg;

    localparam int unsigned DW_DEF  = 32;
    localparam int unsigned DBW_DEF = 256;
    localparam int unsigned BS_DEF  = 4;

    // Extra MSB on the pointer separates full from empty
    function automatic int unsigned ptr_width(input int unsigned bs);
        return $clog2(bs) + 1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned fs);
        return $clog2(fs);
    endfunction

    typedef logic [$clog2(BS_DEF):0] ptr_t;

endpackage

// File: rtl/list_line_buffer.sv
// Ring storage of BS cachelines with a combinational element-select read port.
// With LIST_STREAM_CACHE_LAST_EN defined, a TLAST bit is kept per line.
module list_line_buffer
    import list_cache_pkg::*;
#(
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned DBW = DBW_DEF,
    parameter int unsigned BS  = BS_DEF,
    localparam int unsigned FS = DBW / DW,
    localparam int unsigned LW = ptr_width(BS) - 1,
    localparam int unsigned IW = idx_width(FS)
) (
    input  logic           clk,
    input  logic           wr_en,
    input  logic [LW-1:0]  wr_line,
    input  logic [DBW-1:0] wr_data,
    input  logic           wr_last,
    input  logic [LW-1:0]  rd_line,
    input  logic [IW-1:0]  rd_elem,
    output logic [DW-1:0]  rd_data,
    output logic           rd_last
);

    logic [FS-1:0][DW-1:0] lines [BS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            lines[wr_line] <= wr_data;
        end
    end

    assign rd_data = lines[rd_line][rd_elem];

`ifdef LIST_STREAM_CACHE_LAST_EN
    logic [BS-1:0] last_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            last_q[wr_line] <= wr_last;
        end
    end

    assign rd_last = last_q[rd_line];
`else
    logic unused_last;
    assign unused_last = wr_last;
    assign rd_last     = 1'b0;
`endif

endmodule

// File: rtl/list_stream_cache.sv
// Wide-beat to element-stream unpacker: pointer/full/empty control and output register.
// Define LIST_STREAM_CACHE_LAST_EN to propagate TLAST onto O_LAST.
module list_stream_cache
    import list_cache_pkg::*;
#(
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned DBW = DBW_DEF,
    parameter int unsigned BS  = BS_DEF
) (
    input  logic           ACLK,
    input  logic           ARESET,
    input  logic [DBW-1:0] TDATA,
    input  logic           TVALID,
    output logic           TREADY,
    input  logic           TLAST,
    input  logic           FLUSH,
    input  logic           I_READY,
    output logic [DW-1:0]  OUT,
    output logic           O_VALID,
    output logic           O_LAST
);

    localparam int unsigned FS = DBW / DW;
    localparam int unsigned PW = ptr_width(BS);
    localparam int unsigned LW = PW - 1;
    localparam int unsigned IW = idx_width(FS);

    logic [PW-1:0] wp_q, rp_q;
    logic [IW-1:0] ei_q;
    logic [DW-1:0] out_q;
    logic          valid_q, last_q;

    logic          full, empty, accept, load, elem_end;
    logic [DW-1:0] rd_data;
    logic          rd_last;

    always_comb begin
        full     = (wp_q[PW-1] != rp_q[PW-1]) && (wp_q[LW-1:0] == rp_q[LW-1:0]);
        empty    = (wp_q == rp_q);
        TREADY   = ~full & ~FLUSH & ~ARESET;
        accept   = TVALID & TREADY;
        load     = (~valid_q | I_READY) & ~empty;
        elem_end = (ei_q == IW'(FS - 1));
    end

    list_line_buffer #(
        .DW  (DW),
        .DBW (DBW),
        .BS  (BS)
    ) u_line_buffer (
        .clk     (ACLK),
        .wr_en   (accept),
        .wr_line (wp_q[LW-1:0]),
        .wr_data (TDATA),
        .wr_last (TLAST),
        .rd_line (rp_q[LW-1:0]),
        .rd_elem (ei_q),
        .rd_data (rd_data),
        .rd_last (rd_last)
    );

    // Reset and flush share one path; reset simply wins when both are high
    always_ff @(posedge ACLK) begin
        if (ARESET || FLUSH) begin
            wp_q    <= '0;
            rp_q    <= '0;
            ei_q    <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (accept) begin
                wp_q <= wp_q + PW'(1);
            end
            if (load) begin
                out_q   <= rd_data;
                last_q  <= rd_last & elem_end;
                valid_q <= 1'b1;
                if (elem_end) begin
                    ei_q <= '0;
                    rp_q <= rp_q + PW'(1);
                end else begin
                    ei_q <= ei_q + IW'(1);
                end
            end else if (I_READY) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign OUT     = out_q;
    assign O_VALID = valid_q;
    assign O_LAST  = last_q;

endmodule
